// File: rtl/alu_sequencer.sv
// Issuing controller for the n-bit ALU: accepts one instruction at a time,
// drives the ALU, tracks carry, and writes the registered result into a 4-entry register file.
module alu_sequencer #(
  parameter int unsigned n = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         instr_valid_i,
  input  logic [8:0]   instr_i,
  input  logic [n-1:0] imm_i,
  output logic         instr_ready_o,
  output logic [n-1:0] alu_a_o,
  output logic [n-1:0] alu_b_o,
  output logic [2:0]   alu_op_o,
  output logic         alu_cin_o,
  input  logic [n-1:0] alu_r_i,
  input  logic         alu_cout_i,
  output logic         done_o,
  output logic         carry_o,
  output logic         err_o,
  input  logic [1:0]   dbg_sel_i,
  output logic [n-1:0] dbg_data_o
);

  localparam int unsigned OpW   = 3;
  localparam int unsigned RegW  = 2;
  localparam int unsigned NRegs = 4;

  localparam logic [OpW-1:0] OP_MV  = 3'b000;
  localparam logic [OpW-1:0] OP_ADD = 3'b010;
  localparam logic [OpW-1:0] OP_SUB = 3'b011;
  localparam logic [OpW-1:0] OP_LDI = 3'b110;
  localparam logic [OpW-1:0] OP_RSV = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_CAPT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [OpW-1:0]  op_q, op_d;
  logic [RegW-1:0] rd_q, rd_d;
  logic [n-1:0]    alu_a_q, alu_a_d;
  logic [n-1:0]    alu_b_q, alu_b_d;
  logic [OpW-1:0]  alu_op_q, alu_op_d;
  logic            alu_cin_q, alu_cin_d;
  logic            carry_q, carry_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic [n-1:0]    rf_q [NRegs];
  logic [n-1:0]    rf_d [NRegs];

  logic [OpW-1:0]  in_op;
  logic [RegW-1:0] in_rs;
  logic [RegW-1:0] in_rt;

  assign in_op = instr_i[8:6];
  assign in_rs = instr_i[3:2];
  assign in_rt = instr_i[1:0];

  // Next-state and datapath: ALU drive is set on accept and held until writeback.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    alu_cin_d = alu_cin_q;
    carry_d   = carry_q;
    err_d     = err_q;
    done_d    = 1'b0;
    rf_d      = rf_q;

    case (state_q)
      S_IDLE: begin
        if (instr_valid_i) begin
          op_d      = in_op;
          rd_d      = instr_i[5:4];
          alu_a_d   = (in_op == OP_LDI) ? imm_i : rf_q[in_rs];
          alu_b_d   = rf_q[in_rt];
          alu_op_d  = (in_op == OP_LDI || in_op == OP_RSV) ? OP_MV : in_op;
          alu_cin_d = (in_op == OP_ADD) ? carry_q : 1'b0;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_q == OP_ADD || op_q == OP_SUB) begin
          carry_d = alu_cout_i;
        end
        state_d = S_CAPT;
      end
      S_CAPT: begin
        if (op_q == OP_RSV) begin
          err_d = 1'b1;
        end else begin
          rf_d[rd_q] = alu_r_i;
        end
        done_d    = 1'b1;
        alu_a_d   = '0;
        alu_b_d   = '0;
        alu_op_d  = '0;
        alu_cin_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      alu_cin_q <= 1'b0;
      carry_q   <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      rf_q      <= '{default: '0};
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      alu_cin_q <= alu_cin_d;
      carry_q   <= carry_d;
      err_q     <= err_d;
      done_q    <= done_d;
      rf_q      <= rf_d;
    end
  end

  assign instr_ready_o = (state_q == S_IDLE);
  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign alu_op_o      = alu_op_q;
  assign alu_cin_o     = alu_cin_q;
  assign done_o        = done_q;
  assign carry_o       = carry_q;
  assign err_o         = err_q;
  assign dbg_data_o    = rf_q[dbg_sel_i];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU; expected results are
// queued at issue and checked by a monitor whenever done pulses.
module tb_alu_sequencer;

  localparam int unsigned N = 32;

  localparam logic [2:0] MV  = 3'b000;
  localparam logic [2:0] NOT = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] SUB = 3'b011;
  localparam logic [2:0] OR  = 3'b100;
  localparam logic [2:0] AND = 3'b101;
  localparam logic [2:0] LDI = 3'b110;
  localparam logic [2:0] RSV = 3'b111;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         instr_valid_i = 1'b0;
  logic [8:0]   instr_i = '0;
  logic [N-1:0] imm_i = '0;
  logic         instr_ready_o;
  logic [N-1:0] alu_a_o;
  logic [N-1:0] alu_b_o;
  logic [2:0]   alu_op_o;
  logic         alu_cin_o;
  logic [N-1:0] alu_r_i = '0;
  logic         alu_cout_i;
  logic         done_o;
  logic         carry_o;
  logic         err_o;
  logic [1:0]   dbg_sel_i = '0;
  logic [N-1:0] dbg_data_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0]   rd;
    logic [N-1:0] val;
    logic         carry;
    logic         err;
    logic         wen;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  logic [N-1:0] shadow [4];
  logic         cur_carry = 1'b0;
  bit           last_keep = 1'b0;
  int           last_acc = 0;

  alu_sequencer #(.n(N)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .instr_valid_i (instr_valid_i),
    .instr_i       (instr_i),
    .imm_i         (imm_i),
    .instr_ready_o (instr_ready_o),
    .alu_a_o       (alu_a_o),
    .alu_b_o       (alu_b_o),
    .alu_op_o      (alu_op_o),
    .alu_cin_o     (alu_cin_o),
    .alu_r_i       (alu_r_i),
    .alu_cout_i    (alu_cout_i),
    .done_o        (done_o),
    .carry_o       (carry_o),
    .err_o         (err_o),
    .dbg_sel_i     (dbg_sel_i),
    .dbg_data_o    (dbg_data_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Behavioural ALU: combinational carry-out, result registered one clock later.
  function automatic logic [N:0] alu_calc(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [2:0] op, input logic cin);
    case (op)
      NOT:     alu_calc = {1'b0, ~a};
      ADD:     alu_calc = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
      SUB:     alu_calc = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
      OR:      alu_calc = {1'b0, a | b};
      AND:     alu_calc = {1'b0, a & b};
      default: alu_calc = {1'b0, a};
    endcase
  endfunction

  logic [N:0] alu_res;
  assign alu_res    = alu_calc(alu_a_o, alu_b_o, alu_op_o, alu_cin_o);
  assign alu_cout_i = alu_res[N];
  always @(posedge clk_i) alu_r_i <= alu_res[N-1:0];

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one instruction; keep leaves instr_valid high for a back-to-back follower.
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [1:0] rt, input logic [N-1:0] imm,
                       input logic [N-1:0] val, input logic c, input logic e, input bit keep);
    int   waits = 0;
    int   acc;
    logic [2:0] exp_op;
    logic exp_cin;
    exp_op  = (op == LDI || op == RSV) ? MV : op;
    exp_cin = (op == ADD) ? cur_carry : 1'b0;
    instr_valid_i = 1'b1;
    instr_i = {op, rd, rs, rt};
    imm_i = imm;
    while (!instr_ready_o && waits < 10) begin
      @(posedge clk_i); #1;
      waits++;
    end
    if (!instr_ready_o) begin
      check1("ready_timeout", instr_ready_o, 1'b1);
      instr_valid_i = 1'b0;
      return;
    end
    check("idle_alu_a", alu_a_o, '0);
    check("idle_alu_op", N'(alu_op_o), '0);
    @(posedge clk_i); #1;
    acc = cyc;
    if (last_keep) check("accept_interval", N'(acc - last_acc), N'(3));
    sb.push_back('{rd, val, c, e, (op != RSV), acc});
    instr_i = 9'($urandom);
    imm_i = N'($urandom);
    if (!keep) instr_valid_i = 1'b0;
    check1("exec_ready", instr_ready_o, 1'b0);
    check("exec_alu_op", N'(alu_op_o), N'(exp_op));
    check1("exec_alu_cin", alu_cin_o, exp_cin);
    if (op == LDI) check("exec_alu_a_imm", alu_a_o, imm);
    @(posedge clk_i); #1;
    check("capt_alu_op", N'(alu_op_o), N'(exp_op));
    check1("capt_alu_cin", alu_cin_o, exp_cin);
    last_acc  = acc;
    last_keep = keep;
    cur_carry = c;
  endtask

  // Monitor: every done pulse retires the oldest queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        for (int i = 0; i < 4; i++) shadow[i] = '0;
      end else if (done_o) begin
        if (sb.size() == 0) begin
          check1("done_spurious", done_o, 1'b0);
        end else begin
          e = sb.pop_front();
          if (e.wen) shadow[e.rd] = e.val;
          check("latency", N'(cyc - e.acc), N'(2));
          check1("carry", carry_o, e.carry);
          check1("err", err_o, e.err);
          for (int i = 0; i < 4; i++) begin
            dbg_sel_i = 2'(i);
            #1;
            check($sformatf("rf%0d", i), dbg_data_o, shadow[i]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not end, got t=%0t expected < 50000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int waits;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    check1("rst_ready", instr_ready_o, 1'b1);
    check1("rst_done", done_o, 1'b0);
    check1("rst_carry", carry_o, 1'b0);
    check1("rst_err", err_o, 1'b0);
    check("rst_alu_a", alu_a_o, '0);
    check("rst_alu_b", alu_b_o, '0);
    check("rst_alu_op", N'(alu_op_o), '0);
    check1("rst_alu_cin", alu_cin_o, 1'b0);

    //     op   rd    rs    rt    imm            result         c     e     keep
    issue(LDI, 2'd1, 2'd0, 2'd0, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0, 1'b0);
    issue(LDI, 2'd2, 2'd0, 2'd0, 32'h0000_0003, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
    issue(ADD, 2'd3, 2'd1, 2'd2, 32'h0,         32'h0000_0008, 1'b0, 1'b0, 1'b0);
    issue(SUB, 2'd0, 2'd2, 2'd1, 32'h0,         32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    issue(LDI, 2'd1, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    issue(LDI, 2'd2, 2'd0, 2'd0, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    issue(ADD, 2'd3, 2'd1, 2'd2, 32'h0,         32'h0000_0000, 1'b1, 1'b0, 1'b0);
    issue(OR,  2'd0, 2'd1, 2'd2, 32'h0,         32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    issue(ADD, 2'd0, 2'd2, 2'd2, 32'h0,         32'h0000_0003, 1'b0, 1'b0, 1'b0);
    issue(LDI, 2'd1, 2'd0, 2'd0, 32'h00FF_00F0, 32'h00FF_00F0, 1'b0, 1'b0, 1'b0);
    issue(LDI, 2'd3, 2'd0, 2'd0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    issue(NOT, 2'd1, 2'd1, 2'd1, 32'h0,         32'hFF00_FF0F, 1'b0, 1'b0, 1'b1);
    issue(AND, 2'd2, 2'd1, 2'd3, 32'h0,         32'h1200_5608, 1'b0, 1'b0, 1'b1);
    issue(MV,  2'd0, 2'd2, 2'd0, 32'h0,         32'h1200_5608, 1'b0, 1'b0, 1'b0);
    issue(SUB, 2'd3, 2'd3, 2'd3, 32'h0,         32'h0000_0000, 1'b1, 1'b0, 1'b0);
    issue(RSV, 2'd1, 2'd0, 2'd0, 32'h0,         32'h0,         1'b1, 1'b1, 1'b0);
    issue(MV,  2'd1, 2'd0, 2'd0, 32'h0,         32'h1200_5608, 1'b1, 1'b1, 1'b0);
    repeat (3) @(posedge clk_i);
    #1 check1("err_sticky", err_o, 1'b1);

    // Reset with a valid instruction present: reset wins, nothing is accepted.
    instr_valid_i = 1'b1;
    instr_i = {LDI, 2'd2, 2'd0, 2'd0};
    imm_i = 32'h0000_00AA;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    instr_valid_i = 1'b0;
    check1("rstpri_ready", instr_ready_o, 1'b1);
    check1("rstclr_err", err_o, 1'b0);
    check1("rstclr_carry", carry_o, 1'b0);
    cur_carry = 1'b0;
    last_keep = 1'b0;

    issue(LDI, 2'd1, 2'd0, 2'd0, 32'h0000_0007, 32'h0000_0007, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;

    // ADD r3 = r1 + r1 aborted by reset during CAPT.
    instr_valid_i = 1'b1;
    instr_i = {ADD, 2'd3, 2'd1, 2'd1};
    waits = 0;
    while (!instr_ready_o && waits < 10) begin
      @(posedge clk_i); #1;
      waits++;
    end
    check1("abort_ready_wait", instr_ready_o, 1'b1);
    @(posedge clk_i); #1;
    instr_valid_i = 1'b0;
    @(posedge clk_i); #1;
    check1("abort_in_capt", instr_ready_o, 1'b0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check1("abort_done", done_o, 1'b0);
    check1("abort_ready", instr_ready_o, 1'b1);
    check1("abort_carry", carry_o, 1'b0);
    cur_carry = 1'b0;
    last_keep = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;

    issue(MV,  2'd0, 2'd0, 2'd0, 32'h0,         32'h0000_0000, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk_i);
    #1;
    check("sb_empty", N'(sb.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
